// File: rtl/gpp_data_memory_responder.sv
// gpp_data_memory_responder: 2**ADDR_WIDTH x DATA_WIDTH data store shared by the local GPP port and a queued remote requester
// Ports: clk, rst (sync, active high)
//   local : address_rw, data_in, memory_write_enable -> data_out (combinational read)
//   remote: req_valid/req_ready/req_write/req_addr/req_wdata in, resp_valid/resp_ready/resp_rdata out, rfifo_count
// Macro DMEM_CLEAR_ON_RESET_EN: when defined, rst also zeroes the whole store; otherwise the store keeps its contents
module gpp_data_memory_responder #(
  parameter int ADDR_WIDTH  = 5,
  parameter int DATA_WIDTH  = 16,
  parameter int RFIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [ADDR_WIDTH-1:0]              address_rw,
  input  logic [DATA_WIDTH-1:0]              data_in,
  input  logic                               memory_write_enable,
  output logic [DATA_WIDTH-1:0]              data_out,
  input  logic                               req_valid,
  output logic                               req_ready,
  input  logic                               req_write,
  input  logic [ADDR_WIDTH-1:0]              req_addr,
  input  logic [DATA_WIDTH-1:0]              req_wdata,
  output logic                               resp_valid,
  input  logic                               resp_ready,
  output logic [DATA_WIDTH-1:0]              resp_rdata,
  output logic [$clog2(RFIFO_DEPTH+1)-1:0]   rfifo_count
);
  localparam int PW = $clog2(RFIFO_DEPTH);
  localparam int CW = $clog2(RFIFO_DEPTH+1);
  localparam int EW = 1 + ADDR_WIDTH + DATA_WIDTH;
  typedef enum logic {IDLE, RESP} state_t;
  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
  logic [EW-1:0]         r_fifo [RFIFO_DEPTH];
  logic [PW-1:0]         r_wptr, r_rptr;
  logic [CW-1:0]         r_count;
  logic                  r_resp_valid;
  logic [DATA_WIDTH-1:0] r_resp_rdata;
  state_t                r_state, w_next;
  logic                  w_full, w_empty, w_push, w_pop, w_rwrite, w_rread;
  logic                  w_hwrite;
  logic [ADDR_WIDTH-1:0] w_haddr;
  logic [DATA_WIDTH-1:0] w_hdata;
  assign {w_hwrite, w_haddr, w_hdata} = r_fifo[r_rptr];
  assign w_full      = r_count == CW'(RFIFO_DEPTH);
  assign w_empty     = r_count == '0;
  assign req_ready   = !rst && !w_full;
  assign w_push      = req_valid && req_ready;
  assign data_out    = r_mem[address_rw];
  assign resp_valid  = r_resp_valid;
  assign resp_rdata  = r_resp_rdata;
  assign rfifo_count = r_count;
  // A remote write waits while the local port owns the write port; reads never stall on it.
  always_comb begin
    w_pop    = !rst && r_state == IDLE && !w_empty && !(w_hwrite && memory_write_enable);
    w_rwrite = w_pop && w_hwrite;
    w_rread  = w_pop && !w_hwrite;
    w_next   = r_state == IDLE ? (w_rread ? RESP : IDLE) : (resp_ready ? IDLE : RESP);
  end
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;
  always_ff @(posedge clk) begin
`ifdef DMEM_CLEAR_ON_RESET_EN
    if (rst) for (int i = 0; i < 2**ADDR_WIDTH; i++) r_mem[i] <= '0;
    else
`endif
    if (memory_write_enable) r_mem[address_rw] <= data_in;
    else if (w_rwrite) r_mem[w_haddr] <= w_hdata;
  end
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wptr] <= {req_write, req_addr, req_wdata};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
  // Read data is captured from the pre-edge store, so a same-edge local write is not seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
    end else if (w_rread) begin
      r_resp_valid <= 1'b1;
      r_resp_rdata <= r_mem[w_haddr];
    end else if (r_resp_valid && resp_ready) begin
      r_resp_valid <= 1'b0;
    end
  end
endmodule
